jump_ctrl: RTL and testbench

JUMP_CTRL -- requirements
Module: jump_ctrl

---
 rtl/jump_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_jump_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
// jump_ctrl: push-button jump physics for a single sprite row coordinate.
//
// The raw button is synchronized and debounced. A clean press leaves a
// pending jump request, which is served on the next unpaused game tick if the
// player is standing on the ground. While airborne the player rises under a
// decaying velocity, then falls with velocity growing up to VMAX until the
// ground row is reached again.
//
// Ports:
//   clk_25    in   1  pixel clock, all state on its rising edge
//   rst       in   1  asynchronous active-low reset
//   jump_btn  in   1  raw asynchronous push-button
//   tick      in   1  game-rate strobe, one clk_25 cycle wide
//   pause     in   1  level, freezes motion while high
//   player_y  out 10  current player row (0 = top of screen)
//   airborne  out  1  player is rising or falling
//   jump      out  1  one-cycle pulse when a jump starts
//   land      out  1  one-cycle pulse on touchdown
module jump_ctrl #(
  parameter int GROUND_Y        = 400,
  parameter int V0              = 12,
  parameter int GRAVITY         = 1,
  parameter int VMAX            = 15,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       jump_btn,
  input  logic       tick,
  input  logic       pause,
  output logic [9:0] player_y,
  output logic       airborne,
  output logic       jump,
  output logic       land
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]      GROUND_L = 10'(GROUND_Y);
  localparam logic [5:0]      V0_L     = 6'(V0);
  localparam logic [5:0]      GRAV_L   = 6'(GRAVITY);
  localparam logic [6:0]      VMAX_L   = 7'(VMAX);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    fill_q, fill_d;
  logic          arm_q, arm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          db_prev_q, db_prev_d;
  logic          pending_q, pending_d;
  logic [9:0]    y_q, y_d;
  logic [5:0]    vel_q, vel_d;
  logic          jump_q, jump_d;
  logic          land_q, land_d;
  logic          air_q, air_d;

  logic          btn_s;
  logic          step_s;
  logic          press_s;
  logic [10:0]   fall_sum_s;
  logic [6:0]    vel_inc_s;

  // Button conditioning: synchronizer, debounce counter and press detection.
  always_comb begin
    sync_d    = {sync_q[0], jump_btn};
    btn_s     = sync_q[1];
    // fill_q[1] marks that btn_s carries a real pin sample rather than the
    // reset value of the synchronizer.
    fill_d    = {fill_q[0], 1'b1};
    // A button held through reset must be seen released before a rising
    // debounced level counts as a press.
    arm_d     = arm_q | (fill_q[1] & ~btn_s);
    db_d      = db_q;
    cnt_d     = {CW{1'b0}};
    if (btn_s != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = btn_s;
        cnt_d = {CW{1'b0}};
      end else begin
        db_d  = db_q;
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      db_d  = db_q;
      cnt_d = {CW{1'b0}};
    end
    db_prev_d = db_q;
    press_s   = db_q & ~db_prev_q & arm_q;
  end

  // Motion FSM, evaluated only on unpaused ticks; also owns the pending request.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    vel_d      = vel_q;
    pending_d  = pending_q;
    jump_d     = 1'b0;
    land_d     = 1'b0;
    step_s     = tick & ~pause;
    fall_sum_s = {1'b0, y_q} + {5'b00000, vel_q};
    vel_inc_s  = {1'b0, vel_q} + {1'b0, GRAV_L};
    if (step_s) begin
      // Any request seen at a tick is consumed: served on the ground,
      // discarded while airborne.
      pending_d = 1'b0;
      case (state_q)
        GROUNDED: begin
          if (pending_q) begin
            vel_d   = V0_L;
            state_d = RISING;
            jump_d  = 1'b1;
          end else begin
            vel_d   = vel_q;
            state_d = GROUNDED;
          end
        end
        RISING: begin
          if ({4'b0000, vel_q} > y_q) begin
            y_d = 10'd0;
          end else begin
            y_d = y_q - {4'b0000, vel_q};
          end
          if (vel_q > GRAV_L) begin
            vel_d = vel_q - GRAV_L;
          end else begin
            vel_d   = 6'd0;
            state_d = FALLING;
          end
        end
        FALLING: begin
          if (fall_sum_s >= {1'b0, GROUND_L}) begin
            y_d     = GROUND_L;
            vel_d   = 6'd0;
            state_d = GROUNDED;
            land_d  = 1'b1;
          end else begin
            y_d = fall_sum_s[9:0];
            if (vel_inc_s > VMAX_L) begin
              vel_d = VMAX_L[5:0];
            end else begin
              vel_d = vel_inc_s[5:0];
            end
          end
        end
        default: begin
          y_d     = GROUND_L;
          vel_d   = 6'd0;
          state_d = GROUNDED;
        end
      endcase
    end else begin
      pending_d = pending_q;
    end
    // A new press is only visible from the cycle after its edge, so a tick
    // coinciding with the edge never consumes it.
    pending_d = pending_d | press_s;
    air_d     = (state_d != GROUNDED);
  end

  // State registers, all forced to the grounded idle state by reset.
  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      state_q   <= GROUNDED;
      sync_q    <= 2'b00;
      fill_q    <= 2'b00;
      arm_q     <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      pending_q <= 1'b0;
      y_q       <= GROUND_L;
      vel_q     <= 6'd0;
      jump_q    <= 1'b0;
      land_q    <= 1'b0;
      air_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      fill_q    <= fill_d;
      arm_q     <= arm_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      jump_q    <= jump_d;
      land_q    <= land_d;
      air_q     <= air_d;
    end
  end

  assign player_y = y_q;
  assign airborne = air_q;
  assign jump     = jump_q;
  assign land     = land_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed table of jump scenarios plus randomized
// button/pause/reset stimulus, all checked every cycle against a
// behavioural model of the jump rules.
`timescale 1ns/1ps
module tb_jump_ctrl;

  localparam int GY = 400;
  localparam int V0 = 12;
  localparam int G  = 1;
  localparam int VM = 15;
  localparam int DB = 4;

  logic       clk_25 = 1'b0;
  logic       rst;
  logic       jump_btn;
  logic       tick;
  logic       pause;
  logic [9:0] player_y;
  logic       airborne;
  logic       jump;
  logic       land;

  jump_ctrl #(
    .GROUND_Y(GY), .V0(V0), .GRAVITY(G), .VMAX(VM), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_25(clk_25), .rst(rst), .jump_btn(jump_btn), .tick(tick), .pause(pause),
    .player_y(player_y), .airborne(airborne), .jump(jump), .land(land)
  );

  always #20 clk_25 = ~clk_25;

  int total = 0;
  int bad   = 0;
  int phase = 0;
  int seen_jumps = 0;
  int seen_lands = 0;

  // Behavioural model state
  int m_y, m_vel, m_run;
  bit m_air, m_up, m_pend, m_lvl, m_armed, m_rose, m_jump, m_land;
  bit m_hist[$];

  typedef struct {
    int hi;     // cycles the button is held at the start of the entry
    bit pz;     // pause level for the whole entry
    int n;      // number of tick periods (8 cycles each)
    int y;      // expected player_y at the end
    bit air;    // expected airborne at the end
    int jumps;  // expected jump pulses during the entry
    int lands;  // expected land pulses during the entry
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = GY; m_vel = 0; m_run = 0;
    m_air = 0; m_up = 0; m_pend = 0; m_lvl = 0;
    m_armed = 0; m_rose = 0; m_jump = 0; m_land = 0;
    m_hist.delete();
  endtask

  task automatic model_step(bit b, bit t, bit p);
    bit s;
    bit v;
    int sum;
    m_jump = 0;
    m_land = 0;
    if (t && !p) begin
      if (!m_air) begin
        if (m_pend) begin
          m_vel = V0; m_air = 1; m_up = 1; m_jump = 1;
        end
      end else if (m_up) begin
        m_y = (m_vel > m_y) ? 0 : m_y - m_vel;
        if (m_vel > G) m_vel = m_vel - G;
        else begin m_vel = 0; m_up = 0; end
      end else begin
        sum = m_y + m_vel;
        if (sum >= GY) begin
          m_y = GY; m_vel = 0; m_air = 0; m_land = 1;
        end else begin
          m_y = sum;
          m_vel = (m_vel + G > VM) ? VM : m_vel + G;
        end
      end
      m_pend = 0;
    end
    if (m_rose && m_armed) m_pend = 1;
    // the conditioned logic sees the pin value from two edges ago
    if (m_hist.size() >= 2) begin s = m_hist[m_hist.size()-2]; v = 1; end
    else begin s = 0; v = 0; end
    m_hist.push_back(b);
    if (m_hist.size() > 2) void'(m_hist.pop_front());
    m_rose = 0;
    if (v && !s) m_armed = 1;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == DB) begin m_lvl = s; m_run = 0; m_rose = s; end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic run_cycle();
    tick  = (phase == 7);
    phase = (phase + 1) % 8;
    @(posedge clk_25);
    if (rst) model_step(jump_btn, tick, pause);
    else model_reset();
    @(negedge clk_25);
    chk("y", player_y, m_y);
    chk("airborne", airborne, m_air);
    chk("jump", jump, m_jump);
    chk("land", land, m_land);
    if (jump) seen_jumps++;
    if (land) seen_lands++;
  endtask

  task automatic apply_entry(int idx, vec_t e);
    seen_jumps = 0;
    seen_lands = 0;
    for (int c = 0; c < e.n * 8; c++) begin
      jump_btn = (c < e.hi);
      pause    = e.pz;
      run_cycle();
    end
    chk($sformatf("v%0d_y", idx), player_y, e.y);
    chk($sformatf("v%0d_air", idx), airborne, e.air);
    chk($sformatf("v%0d_jumps", idx), seen_jumps, e.jumps);
    chk($sformatf("v%0d_lands", idx), seen_lands, e.lands);
  endtask

  function automatic void add(int hi, bit pz, int n, int y, bit air, int j, int l);
    vec_t e;
    e.hi = hi; e.pz = pz; e.n = n; e.y = y; e.air = air; e.jumps = j; e.lands = l;
    tbl.push_back(e);
  endfunction

  initial begin
    vec_t e;
    int hold;
    int rst_left;

    // full jump and glitch
    add(0, 0, 1, 400, 0, 0, 0);
    add(8, 0, 1, 400, 1, 1, 0);
    add(0, 0, 6, 343, 1, 0, 0);
    add(0, 0, 6, 322, 1, 0, 0);
    add(0, 0, 12, 388, 1, 0, 0);
    add(0, 0, 1, 400, 0, 0, 1);
    add(3, 0, 2, 400, 0, 0, 0);
    add(0, 0, 2, 400, 0, 0, 0);
    // press while rising is discarded
    add(8, 0, 1, 400, 1, 1, 0);
    add(0, 0, 5, 350, 1, 0, 0);
    add(8, 0, 1, 343, 1, 0, 0);
    add(0, 0, 6, 322, 1, 0, 0);
    add(0, 0, 13, 400, 0, 0, 1);
    add(0, 0, 3, 400, 0, 0, 0);
    // pause mid-jump, trajectory resumes unchanged
    add(8, 0, 1, 400, 1, 1, 0);
    add(0, 0, 4, 358, 1, 0, 0);
    add(0, 1, 10, 358, 1, 0, 0);
    add(0, 0, 8, 322, 1, 0, 0);
    add(0, 0, 13, 400, 0, 0, 1);
    // press during pause on the ground is served after unpause
    add(8, 1, 1, 400, 0, 0, 0);
    add(0, 1, 2, 400, 0, 0, 0);
    add(0, 0, 1, 400, 1, 1, 0);
    add(0, 0, 12, 322, 1, 0, 0);
    add(0, 0, 13, 400, 0, 0, 1);
    // climb to y=350 on the way down, ready for the reset check
    add(8, 0, 1, 400, 1, 1, 0);
    add(0, 0, 12, 322, 1, 0, 0);
    add(0, 0, 8, 350, 1, 0, 0);

    rst = 1'b0; jump_btn = 1'b0; tick = 1'b0; pause = 1'b0;
    model_reset();
    repeat (8) run_cycle();
    chk("reset_y", player_y, 400);
    chk("reset_air", airborne, 0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      apply_entry(i, e);
    end

    // asynchronous reset mid-fall takes effect without a clock edge
    rst = 1'b0;
    #2;
    chk("async_rst_y", player_y, 400);
    chk("async_rst_air", airborne, 0);
    chk("async_rst_jump", jump, 0);
    chk("async_rst_land", land, 0);
    model_reset();
    repeat (8) run_cycle();
    rst = 1'b1;
    e.hi = 0; e.pz = 0; e.n = 3; e.y = 400; e.air = 0; e.jumps = 0; e.lands = 0;
    apply_entry(100, e);

    // button held through reset is not a press until released and pressed again
    jump_btn = 1'b1;
    rst = 1'b0;
    repeat (8) run_cycle();
    rst = 1'b1;
    e.hi = 24; e.n = 3; e.y = 400; e.air = 0; e.jumps = 0; e.lands = 0;
    apply_entry(101, e);
    e.hi = 0; e.n = 1;
    apply_entry(102, e);
    e.hi = 8; e.n = 1; e.y = 400; e.air = 1; e.jumps = 1;
    apply_entry(103, e);
    e.hi = 0; e.n = 25; e.y = 400; e.air = 0; e.jumps = 0; e.lands = 1;
    apply_entry(104, e);

    // randomized stimulus against the model
    hold = 0;
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        jump_btn = ($urandom_range(0, 1) == 1);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      if (rst_left > 0) begin
        rst_left--;
        rst = (rst_left == 0);
      end else if ($urandom_range(0, 699) == 0) begin
        rst = 1'b0;
        rst_left = $urandom_range(1, 3);
      end
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
